// File: rtl/vga_image_sprite_fetch_if.sv
// Image ROM bus between the sprite fetcher (master) and a synchronous ROM (slave).
interface vga_image_sprite_fetch_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, output rom_en, input rom_data);
  modport slave  (input rom_addr, input rom_en, output rom_data);
endinterface

// File: rtl/vga_image_sprite_fetch.sv
// Image fetcher: places an IMG_W x IMG_H ROM image (x1/x2/x4) at a per-frame
// latched origin inside the visible area, background colour elsewhere, black
// in blanking. Two pixel_ce edges from coordinate to colour.
module vga_image_sprite_fetch #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned IMG_W   = 600,
  parameter int unsigned IMG_H   = 500,
  parameter int unsigned H_VIS   = 800,
  parameter int unsigned V_VIS   = 600,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pixel_ce,
  input  logic [31:0]            pixel_count,
  input  logic [31:0]            line_count,
  input  logic [31:0]            h_back_porch,
  input  logic [31:0]            v_back_porch,
  input  logic                   enable,
  input  logic [15:0]            x_org,
  input  logic [15:0]            y_org,
  input  logic [1:0]             scale_sel,
  input  logic [3*COLOR_W-1:0]   bg_color,
  vga_image_sprite_fetch_if.master rom,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     green_out,
  output logic [COLOR_W-1:0]     blue_out
);

  localparam logic [31:0]       IMG_W32   = 32'(IMG_W);
  localparam logic [31:0]       IMG_H32   = 32'(IMG_H);
  localparam logic [31:0]       H_VIS32   = 32'(H_VIS);
  localparam logic [31:0]       V_VIS32   = 32'(V_VIS);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  // Per-frame shadows
  logic                 en_sh;
  logic [2:0]           scale_sh;
  logic [31:0]          xo_sh;
  logic [31:0]          yo_sh;
  logic [3*COLOR_W-1:0] bg_sh;

  // Fetch state
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    row_base;
  logic [1:0]           hrep;
  logic [1:0]           vrep;

  // Colour stage
  logic                 d_in_img;
  logic                 d_vis;
  logic [3*COLOR_W-1:0] rgb;

  logic                 frame_start;
  logic [2:0]           scale_new;
  logic [31:0]          xo_lim;
  logic [31:0]          yo_lim;
  logic [31:0]          xo_new;
  logic [31:0]          yo_new;
  logic [31:0]          span_w;
  logic [31:0]          span_h;
  logic [31:0]          vx;
  logic [31:0]          vy;
  logic                 visible;
  logic                 in_img;
  logic [2:0]           s_m1;
  logic                 rep_last;
  logic                 vrep_last;
  logic                 col_last;

  // Scale decode, clamped origins for the next frame, and current-frame geometry
  always_comb begin
    frame_start = pixel_ce && (pixel_count == '0) && (line_count == '0);
    case (scale_sel)
      2'd1:    scale_new = 3'd2;
      2'd2:    scale_new = 3'd4;
      default: scale_new = 3'd1;
    endcase
    xo_lim  = H_VIS32 - IMG_W32 * 32'(scale_new);
    yo_lim  = V_VIS32 - IMG_H32 * 32'(scale_new);
    xo_new  = ({16'b0, x_org} < xo_lim) ? {16'b0, x_org} : xo_lim;
    yo_new  = ({16'b0, y_org} < yo_lim) ? {16'b0, y_org} : yo_lim;

    span_w  = IMG_W32 * 32'(scale_sh);
    span_h  = IMG_H32 * 32'(scale_sh);
    vx      = pixel_count - h_back_porch;
    vy      = line_count - v_back_porch;
    visible = (vx < H_VIS32) && (vy < V_VIS32);
    in_img  = en_sh && (vx >= xo_sh) && (vx < xo_sh + span_w)
                    && (vy >= yo_sh) && (vy < yo_sh + span_h);

    s_m1      = scale_sh - 3'd1;
    rep_last  = ({1'b0, hrep} == s_m1);
    vrep_last = ({1'b0, vrep} == s_m1);
    col_last  = ((addr - row_base) == (ROW_STEP - 1'b1));
  end

  // ROM request is gated by pixel_ce so the ROM word holds between strobes
  assign rom.rom_en   = pixel_ce && in_img;
  assign rom.rom_addr = addr;

  // Latch placement settings once per frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_sh    <= 1'b0;
      scale_sh <= 3'd1;
      xo_sh    <= '0;
      yo_sh    <= '0;
      bg_sh    <= '0;
    end else if (frame_start) begin
      en_sh    <= enable;
      scale_sh <= scale_new;
      xo_sh    <= xo_new;
      yo_sh    <= yo_new;
      bg_sh    <= bg_color;
    end
  end

  // Address walk: replicate pixels horizontally, replay rows vertically
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      row_base <= '0;
      hrep     <= '0;
      vrep     <= '0;
    end else if (pixel_ce) begin
      if (frame_start) begin
        addr     <= '0;
        row_base <= '0;
        hrep     <= '0;
        vrep     <= '0;
      end else if (in_img) begin
        if (!rep_last) begin
          hrep <= hrep + 2'd1;
        end else begin
          hrep <= '0;
          if (!col_last) begin
            addr <= addr + 1'b1;
          end else if (!vrep_last) begin
            vrep <= vrep + 2'd1;
            addr <= row_base;
          end else begin
            vrep <= '0;
            if (addr == LAST_ADDR) begin
              addr     <= '0;
              row_base <= '0;
            end else begin
              row_base <= row_base + ROW_STEP;
              addr     <= row_base + ROW_STEP;
            end
          end
        end
      end
    end
  end

  // Colour select one strobe after the fetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_in_img <= 1'b0;
      d_vis    <= 1'b0;
      rgb      <= '0;
    end else if (pixel_ce) begin
      d_in_img <= in_img;
      d_vis    <= visible;
      rgb      <= d_in_img ? rom.rom_data : (d_vis ? bg_sh : '0);
    end
  end

  assign red_out   = rgb[3*COLOR_W-1 -: COLOR_W];
  assign green_out = rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue_out  = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_image_sprite_fetch.sv
// Randomised bench for vga_image_sprite_fetch against a per-pixel reference model.
module tb_vga_image_sprite_fetch;
  localparam int CW = 4, IW = 4, IH = 3, HV = 16, VV = 12, AW = 4;
  localparam int HBP = 2, VBP = 2, HTOT = 20, VTOT = 16, NT = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_ce;
  logic [31:0] pixel_count, line_count, hbp, vbp;
  logic        enable;
  logic [15:0] x_org, y_org;
  logic [1:0]  scale_sel;
  logic [11:0] bg_color;
  logic [3:0]  red_out, green_out, blue_out;

  always #5 clk = ~clk;

  vga_image_sprite_fetch_if #(.ADDR_W(AW), .DATA_W(3 * CW)) rif ();

  vga_image_sprite_fetch #(
    .COLOR_W(CW), .IMG_W(IW), .IMG_H(IH), .H_VIS(HV), .V_VIS(VV), .ADDR_W(AW)
  ) dut (
    .clock(clk), .reset(rst), .pixel_ce(pixel_ce),
    .pixel_count(pixel_count), .line_count(line_count),
    .h_back_porch(hbp), .v_back_porch(vbp),
    .enable(enable), .x_org(x_org), .y_org(y_org),
    .scale_sel(scale_sel), .bg_color(bg_color),
    .rom(rif),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
  );

  // Synchronous image ROM, one clock latency
  logic [11:0] mem [16];
  always @(posedge clk) if (rif.rom_en) rif.rom_data <= mem[rif.rom_addr];

  int compared = 0, mismatched = 0;

  // Reference model state
  bit          m_en;
  int          m_s, m_xo, m_yo;
  logic [11:0] m_bg;
  bit          prev_in, prev_vis;
  int          prev_addr;
  bit          seen_en;
  int          first_pc, first_lc;
  logic [11:0] frame_rgb [NT];
  logic [11:0] ref_rgb [NT];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dec_scale(input logic [1:0] sel);
    return (sel == 2'd1) ? 2 : (sel == 2'd2) ? 4 : 1;
  endfunction

  task automatic model_latch();
    int lim;
    m_en = enable;
    m_s  = dec_scale(scale_sel);
    lim  = HV - IW * m_s;
    m_xo = (int'(x_org) < lim) ? int'(x_org) : lim;
    lim  = VV - IH * m_s;
    m_yo = (int'(y_org) < lim) ? int'(y_org) : lim;
    m_bg = bg_color;
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_s = 1; m_xo = 0; m_yo = 0; m_bg = '0;
    prev_in = 1'b0; prev_vis = 1'b0; prev_addr = 0;
  endtask

  task automatic randomize_cfg();
    x_org     = 16'($urandom_range(0, 24));
    y_org     = 16'($urandom_range(0, 20));
    scale_sel = 2'($urandom_range(0, 3));
    bg_color  = 12'($urandom);
    enable    = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pixel_ce = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rgb_in_reset", 32'({red_out, green_out, blue_out}), 32'd0);
    check_eq("rom_en_in_reset", 32'(rif.rom_en), 32'd0);
    check_eq("rom_addr_in_reset", 32'(rif.rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One pixel strobe at (pc, lc), preceded by div-1 idle clocks
  task automatic tick(input int pc, input int lc, input int div, input int t);
    int vx, vy, a;
    bit vis, img;
    logic [11:0] exp_rgb;
    repeat (div - 1) begin
      @(negedge clk);
      pixel_ce = 1'b0;
      #1 check_eq("rom_en_no_ce", 32'(rif.rom_en), 32'd0);
    end
    @(negedge clk);
    pixel_ce = 1'b1;
    pixel_count = 32'(pc);
    line_count  = 32'(lc);
    vx  = pc - HBP;
    vy  = lc - VBP;
    vis = (vx >= 0) && (vx < HV) && (vy >= 0) && (vy < VV);
    img = m_en && (vx >= m_xo) && (vx < m_xo + IW * m_s) && (vy >= m_yo) && (vy < m_yo + IH * m_s);
    a   = img ? ((vy - m_yo) / m_s) * IW + (vx - m_xo) / m_s : 0;
    #1;
    seen_en = rif.rom_en;
    check_eq("rom_en", 32'(rif.rom_en), 32'(img));
    if (img) check_eq("rom_addr", 32'(rif.rom_addr), 32'(a));
    exp_rgb = prev_in ? mem[prev_addr] : (prev_vis ? m_bg : 12'h000);
    @(posedge clk);
    #1;
    frame_rgb[t] = {red_out, green_out, blue_out};
    check_eq("rgb", 32'({red_out, green_out, blue_out}), 32'(exp_rgb));
    prev_in = img; prev_vis = vis; prev_addr = a;
    if (pc == 0 && lc == 0) model_latch();
  endtask

  task automatic run_frame(input int div, input int rst_at, input int chg_at);
    int reads, exp_reads;
    bit had_rst;
    reads = 0; exp_reads = 0; had_rst = 1'b0;
    first_pc = -1; first_lc = -1;
    for (int t = 0; t < NT; t++) begin
      if (t == rst_at) begin
        do_reset();
        had_rst = 1'b1;
      end
      if (t == chg_at) randomize_cfg();
      tick(t % HTOT, t / HTOT, div, t);
      if (t == 0) exp_reads = m_en ? IW * IH * m_s * m_s : 0;
      if (seen_en) begin
        reads++;
        if (first_pc < 0) begin
          first_pc = t % HTOT;
          first_lc = t / HTOT;
        end
      end
    end
    if (!had_rst) check_eq("reads_per_frame", 32'(reads), 32'(exp_reads));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
    pixel_ce = 1'b0; pixel_count = '0; line_count = '0;
    hbp = 32'(HBP); vbp = 32'(VBP);
    enable = 1'b1; x_org = 16'd3; y_org = 16'd2; scale_sel = 2'd0; bg_color = 12'h5A3;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    check_eq("reset_rom_en", 32'(rif.rom_en), 32'd0);
    check_eq("reset_rom_addr", 32'(rif.rom_addr), 32'd0);
    rst = 1'b0;

    // x1 at (3,2), then reset in the middle of the image, then a clean frame
    run_frame(1, -1, -1);
    run_frame(1, 5 * HTOT + 6, -1);
    run_frame(1, -1, -1);
    check_eq("first_read_x_x1", 32'(first_pc), 32'(HBP + 3));
    check_eq("first_read_y_x1", 32'(first_lc), 32'(VBP + 2));

    // x2 and clamped x2
    scale_sel = 2'd1;
    run_frame(1, -1, -1);
    x_org = 16'd20; y_org = 16'd20;
    run_frame(1, -1, -1);
    check_eq("clamp_first_x", 32'(first_pc), 32'(HBP + 8));
    check_eq("clamp_first_y", 32'(first_lc), 32'(VBP + 6));

    // Mid-frame settings change, seen only from the next frame
    run_frame(1, -1, 100);
    run_frame(1, -1, -1);

    // Disabled image: background only, no reads
    enable = 1'b0; bg_color = 12'hF0F;
    run_frame(1, -1, -1);

    // Same configuration with pixel_ce every clock and every 4th clock
    enable = 1'b1; x_org = 16'd5; y_org = 16'd3; scale_sel = 2'd2;
    run_frame(1, -1, -1);
    for (int i = 0; i < NT; i++) ref_rgb[i] = frame_rgb[i];
    run_frame(4, -1, -1);
    for (int i = 0; i < NT; i++) check_eq("ce_rate_rgb", 32'(frame_rgb[i]), 32'(ref_rgb[i]));

    // Random frames
    for (int f = 0; f < 6; f++) begin
      randomize_cfg();
      run_frame(int'($urandom_range(1, 4)), -1,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, NT - 1)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
